// File: rtl/tree_walk_engine.sv
// Decision-tree ensemble evaluator: walks N_TREES binary trees over a latched
// feature vector, one node per cycle, and reports the leaf-vote majority.
module tree_walk_engine #(
    parameter int N_FEAT    = 51,
    parameter int FIDX_W    = 6,
    parameter int ADDR_W    = 7,
    parameter int N_TREES   = 4,
    parameter int MAX_DEPTH = 16,
    localparam int NODE_W   = 2 + FIDX_W + 2 * ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic              cfg_root,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [NODE_W-1:0] cfg_data,
    output logic              cfg_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_FEAT-1:0] in_feat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_class,
    output logic [4:0]        out_votes,
    output logic              out_err
);

    localparam int STEP_W = $clog2(MAX_DEPTH + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_DEPTH - 1);
    localparam logic [3:0]        TREE_LAST = 4'(N_TREES - 1);
    localparam logic [5:0]        N_TREES_6 = 6'(N_TREES);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t              state_reg;
    logic [N_FEAT-1:0]   feat_reg;
    logic [3:0]          tree_reg;
    logic [ADDR_W-1:0]   node_reg;
    logic [STEP_W-1:0]   steps_reg;
    logic [4:0]          votes_reg;
    logic                err_reg;

    logic [NODE_W-1:0]   node_mem [2**ADDR_W];
    logic [ADDR_W-1:0]   root_mem [16];

    logic                cfg_open;
    logic [NODE_W-1:0]   cur_node;
    logic                cur_leaf;
    logic                cur_val;
    logic [FIDX_W-1:0]   cur_fidx;
    logic [ADDR_W-1:0]   cur_child_t;
    logic [ADDR_W-1:0]   cur_child_f;
    logic [2**FIDX_W-1:0] feat_ext;
    logic                feat_bit;

    logic                tree_end;
    logic                leaf_bit;
    logic                err_next;
    logic [ADDR_W-1:0]   node_next;
    logic [4:0]          votes_next;
    logic                class_next;
    logic [3:0]          tree_inc;

    assign cfg_open  = (state_reg == IDLE);
    assign in_ready  = cfg_open;
    assign cfg_ready = cfg_open;

    // Node table: no reset, written only while idle, read combinationally.
    always_ff @(posedge clk) begin
        if (cfg_we && !cfg_root && cfg_open) begin
            node_mem[cfg_addr] <= cfg_data;
        end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_root
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                root_mem[gi] <= '0;
            end else if (cfg_we && cfg_root && cfg_open && cfg_addr[3:0] == 4'(gi)) begin
                root_mem[gi] <= cfg_data[ADDR_W-1:0];
            end
        end
    end

    // Feature indices past N_FEAT resolve to a constant 0 bit.
    for (genvar gi = 0; gi < 2**FIDX_W; gi++) begin : g_feat
        if (gi < N_FEAT) begin : g_real
            assign feat_ext[gi] = feat_reg[gi];
        end else begin : g_pad
            assign feat_ext[gi] = 1'b0;
        end
    end

    assign cur_node    = node_mem[node_reg];
    assign cur_leaf    = cur_node[NODE_W-1];
    assign cur_val     = cur_node[NODE_W-2];
    assign cur_fidx    = cur_node[NODE_W-3 -: FIDX_W];
    assign cur_child_t = cur_node[2*ADDR_W-1 -: ADDR_W];
    assign cur_child_f = cur_node[ADDR_W-1:0];
    assign feat_bit    = feat_ext[cur_fidx];

    always_comb begin
        tree_end  = 1'b0;
        leaf_bit  = 1'b0;
        err_next  = err_reg;
        node_next = feat_bit ? cur_child_t : cur_child_f;
        if (cur_leaf) begin
            tree_end = 1'b1;
            leaf_bit = cur_val;
        end else if (steps_reg == STEP_LAST) begin
            // Depth guard: the tree is abandoned and contributes no vote.
            tree_end = 1'b1;
            err_next = 1'b1;
        end
    end

    assign votes_next = votes_reg + {4'd0, leaf_bit};
    assign class_next = ({votes_next, 1'b0} > N_TREES_6);
    assign tree_inc   = tree_reg + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            feat_reg  <= '0;
            tree_reg  <= '0;
            node_reg  <= '0;
            steps_reg <= '0;
            votes_reg <= '0;
            err_reg   <= 1'b0;
            out_valid <= 1'b0;
            out_class <= 1'b0;
            out_votes <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        feat_reg  <= in_feat;
                        tree_reg  <= '0;
                        node_reg  <= root_mem[0];
                        steps_reg <= '0;
                        votes_reg <= '0;
                        err_reg   <= 1'b0;
                        state_reg <= WALK;
                    end
                end
                WALK: begin
                    if (tree_end) begin
                        votes_reg <= votes_next;
                        err_reg   <= err_next;
                        if (tree_reg == TREE_LAST) begin
                            state_reg <= DONE;
                            out_valid <= 1'b1;
                            out_votes <= votes_next;
                            out_class <= class_next;
                            out_err   <= err_next;
                        end else begin
                            tree_reg  <= tree_inc;
                            node_reg  <= root_mem[tree_inc];
                            steps_reg <= '0;
                        end
                    end else begin
                        node_reg  <= node_next;
                        steps_reg <= steps_reg + STEP_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tree_walk_engine.sv
// Scoreboard bench for tree_walk_engine: directed tree tables plus random tables,
// predicted by a tree-walking reference model and checked by a decoupled monitor.
module tb_tree_walk_engine;

    localparam int N_FEAT    = 51;
    localparam int FIDX_W    = 6;
    localparam int ADDR_W    = 7;
    localparam int N_TREES   = 4;
    localparam int MAX_DEPTH = 16;
    localparam int NODE_W    = 2 + FIDX_W + 2 * ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic              cfg_root = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [NODE_W-1:0] cfg_data = '0;
    logic              cfg_ready;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N_FEAT-1:0] in_feat = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_class;
    logic [4:0]        out_votes;
    logic              out_err;

    tree_walk_engine #(
        .N_FEAT(N_FEAT), .FIDX_W(FIDX_W), .ADDR_W(ADDR_W),
        .N_TREES(N_TREES), .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_root(cfg_root), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_votes(out_votes), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int votes;
        int cls;
        int err;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   have_cur = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   bp_mode  = 2;   // 0 random out_ready, 1 held low, 2 held high

    logic [NODE_W-1:0] m_node [2**ADDR_W];
    logic [ADDR_W-1:0] m_root [16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0: out_ready = ($urandom_range(0, 3) != 0);
            1: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NODE_W-1:0] mk_node(input logic leaf, input logic val,
            input logic [FIDX_W-1:0] fi, input logic [ADDR_W-1:0] ct, input logic [ADDR_W-1:0] cf);
        return {leaf, val, fi, ct, cf};
    endfunction

    // Reference: follow each tree from its root by the node-word rules.
    function automatic void predict(input logic [N_FEAT-1:0] f, output int v, output int e, output int lat);
        int n;
        int fi;
        logic [NODE_W-1:0] w;
        logic b;
        v = 0; e = 0; lat = 0;
        for (int t = 0; t < N_TREES; t++) begin
            n = int'(m_root[t]);
            for (int s = 0; s < MAX_DEPTH; s++) begin
                w = m_node[n];
                lat++;
                if (w[NODE_W-1]) begin
                    v += int'(w[NODE_W-2]);
                    break;
                end
                if (s == MAX_DEPTH - 1) begin
                    e = 1;
                    break;
                end
                fi = int'(w[NODE_W-3 -: FIDX_W]);
                b  = (fi < N_FEAT) ? f[fi] : 1'b0;
                n  = b ? int'(w[2*ADDR_W-1 -: ADDR_W]) : int'(w[ADDR_W-1:0]);
            end
        end
    endfunction

    // Monitor: pops one expectation per result and checks it every held cycle.
    always @(negedge clk) begin
        if (rst) begin
            have_cur = 0;
        end else if (out_valid) begin
            if (!have_cur) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", int'(out_valid), 0);
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1;
                    chk("latency", cyc - cur.acc, cur.lat);
                end
            end
            if (have_cur) begin
                $display("result votes=%0d class=%0d err=%0d ready=%0b", out_votes, out_class, out_err, out_ready);
                chk("out_votes", int'(out_votes), cur.votes);
                chk("out_class", int'(out_class), cur.cls);
                chk("out_err", int'(out_err), cur.err);
                chk("in_ready_in_done", int'(in_ready), 0);
                if (out_ready) have_cur = 0;
            end
        end
    end

    function automatic logic [N_FEAT-1:0] rand_feat();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[N_FEAT-1:0];
    endfunction

    task automatic cfg_write(input bit root, input int addr, input logic [NODE_W-1:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_root = root; cfg_addr = ADDR_W'(addr); cfg_data = d;
        @(negedge clk);
        chk("cfg_ready", int'(cfg_ready), 1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (root) m_root[addr % 16] = d[ADDR_W-1:0];
        else      m_node[addr] = d;
    endtask

    task automatic set_roots(input int r0, input int r1, input int r2, input int r3);
        cfg_write(1, 0, NODE_W'(r0));
        cfg_write(1, 1, NODE_W'(r1));
        cfg_write(1, 2, NODE_W'(r2));
        cfg_write(1, 3, NODE_W'(r3));
    endtask

    task automatic send_sample(input logic [N_FEAT-1:0] f);
        exp_t e;
        int k;
        predict(f, e.votes, e.err, e.lat);
        e.cls = (2 * e.votes > N_TREES) ? 1 : 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_feat = f;
        k = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 500) begin
                chk("accept_timeout", int'(in_ready), 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        e.acc = cyc;
        sb.push_back(e);
        $display("sample accepted feat=%h exp votes=%0d class=%0d err=%0d lat=%0d", f, e.votes, e.cls, e.err, e.lat);
        in_valid = 1'b0;
        in_feat = rand_feat();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !have_cur && in_ready) return;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        logic [N_FEAT-1:0] f;
        int wk;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_votes", int'(out_votes), 0);
        chk("rst_out_class", int'(out_class), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 16; i++) m_root[i] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cfg_ready", int'(cfg_ready), 1);

        cfg_write(0, 0, mk_node(1'b0, 1'b0, 6'd6, 7'd1, 7'd2));
        cfg_write(0, 1, mk_node(1'b1, 1'b0, 6'd0, 7'd0, 7'd0));
        cfg_write(0, 2, mk_node(1'b1, 1'b1, 6'd0, 7'd0, 7'd0));
        cfg_write(0, 3, mk_node(1'b0, 1'b0, 6'd0, 7'd3, 7'd3));
        cfg_write(0, 4, mk_node(1'b0, 1'b0, 6'd55, 7'd2, 7'd1));
        cfg_write(0, 5, mk_node(1'b1, 1'b1, 6'd0, 7'd0, 7'd0));

        // Leaf at every root.
        set_roots(5, 5, 5, 5);
        send_sample(rand_feat());
        wait_idle();

        // Depth-2 path through feature 6, both directions.
        set_roots(0, 0, 0, 0);
        f = rand_feat(); f[6] = 1'b0;
        send_sample(f);
        f = rand_feat(); f[6] = 1'b1;
        send_sample(f);
        wait_idle();

        // Majority tie and clear majority.
        set_roots(2, 2, 1, 1);
        send_sample(rand_feat());
        wait_idle();
        set_roots(2, 2, 2, 1);
        send_sample(rand_feat());
        wait_idle();

        // Depth guard on a self-looping node.
        set_roots(3, 2, 2, 2);
        send_sample(rand_feat());
        wait_idle();

        // Out-of-range feature index reads as 0.
        set_roots(4, 4, 4, 4);
        send_sample('1);
        wait_idle();

        // Backpressure with configuration lockout.
        set_roots(2, 2, 2, 2);
        bp_mode = 1;
        send_sample(rand_feat());
        wk = 0;
        while (!out_valid && wk < 300) begin
            @(negedge clk);
            wk++;
        end
        chk("bp_reach_done", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            cfg_we   = (i == 2 || i == 4);
            cfg_root = (i == 4);
            cfg_addr = (i == 4) ? ADDR_W'(0) : ADDR_W'(2);
            cfg_data = (i == 4) ? NODE_W'(1) : mk_node(1'b1, 1'b0, 6'd0, 7'd0, 7'd0);
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            if (cfg_we) chk("lockout_cfg_ready", int'(cfg_ready), 0);
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
        bp_mode = 2;
        wait_idle();
        send_sample(rand_feat());
        wait_idle();

        // Reset in the third walk cycle aborts the sample.
        set_roots(3, 3, 3, 3);
        send_sample(rand_feat());
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        void'(sb.pop_back());
        for (int i = 0; i < 16; i++) m_root[i] = '0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_first_in_ready", int'(in_ready), 1);
        repeat (70) @(negedge clk);
        f = rand_feat(); f[6] = 1'b0;
        send_sample(f);
        wait_idle();

        // Random tables with random backpressure.
        for (int i = 0; i < 2**ADDR_W; i++) begin
            cfg_write(0, i, mk_node(($urandom_range(0, 2) == 0), 1'($urandom),
                                    6'($urandom_range(0, 63)), 7'($urandom), 7'($urandom)));
        end
        set_roots($urandom_range(0, 127), $urandom_range(0, 127),
                  $urandom_range(0, 127), $urandom_range(0, 127));
        bp_mode = 0;
        for (int i = 0; i < 40; i++) send_sample(rand_feat());
        bp_mode = 2;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tree_walk_engine.md
TREE_WALK_ENGINE -- requirements
Module: tree_walk_engine

Interface
REQ-001 Parameter N_FEAT, default 51: width of the binary feature vector.
REQ-002 Parameter FIDX_W, default 6: feature-index width; 2**FIDX_W SHALL be >= N_FEAT.
REQ-003 Parameter ADDR_W, default 7: node-table address width; table depth is 2**ADDR_W.
REQ-004 Parameter N_TREES, default 4: trees evaluated per sample; range 1..16.
REQ-005 Parameter MAX_DEPTH, default 16: maximum nodes visited per tree.
REQ-006 One clock; reset is asynchronous and active-high: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-007 cfg_we input 1: write strobe for the node table or the root table.
REQ-008 cfg_root input 1: 1 = write root table, 0 = write node table.
REQ-009 cfg_addr input ADDR_W: node address, or tree index in the low 4 bits when cfg_root=1.
REQ-010 cfg_data input NODE_W: node word {leaf, leaf_val, feat_idx[FIDX_W], child_t[ADDR_W], child_f[ADDR_W]}, with NODE_W=2+FIDX_W+2*ADDR_W; root writes use the low ADDR_W bits.
REQ-011 cfg_ready output 1: high when a configuration write is accepted.
REQ-012 in_valid input 1 / in_ready output 1 / in_feat input N_FEAT: sample handshake.
REQ-013 out_valid output 1 / out_ready input 1: result handshake.
REQ-014 out_class output 1: majority decision.
REQ-015 out_votes output 5: count of trees whose leaf value is 1.
REQ-016 out_err output 1: at least one tree hit the depth guard.

Function
REQ-017 FSM states SHALL be IDLE, WALK and DONE.
REQ-018 in_ready and cfg_ready SHALL be 1 only in IDLE.
REQ-019 cfg_we SHALL be ignored outside IDLE; node and root writes take effect at the next clock edge.
REQ-020 In IDLE, when in_valid is high, the block SHALL latch in_feat, set tree=0, node=root[0], steps=0, votes=0, err=0 and enter WALK.
REQ-021 In WALK, node-table reads SHALL be combinational, and exactly one node SHALL be evaluated per cycle.
REQ-022 Non-leaf node in WALK: next node = feat[feat_idx] ? child_t : child_f, and steps increments.
REQ-023 A feat_idx >= N_FEAT SHALL read the feature as 0.
REQ-024 Leaf node in WALK: votes += leaf_val; if tree == N_TREES-1, go to DONE; otherwise tree++, node=root[tree], steps=0.
REQ-025 Depth guard: evaluating a non-leaf node when steps == MAX_DEPTH-1 SHALL end the tree with leaf value 0 and set err=1.
REQ-026 Latency from the accept edge to out_valid high SHALL be the total number of nodes evaluated across all trees, plus 0 additional cycles (out_valid asserts in the cycle after the final leaf).
REQ-027 In DONE, out_valid=1 and out_votes, out_err and out_class SHALL be held stable until out_ready=1, then the FSM returns to IDLE.
REQ-028 out_class SHALL be 1 iff 2*votes > N_TREES; ties resolve to 0.
REQ-029 out_valid and out_ready high in the same cycle as in_valid SHALL NOT accept the new sample that cycle; acceptance occurs in the following IDLE cycle (no bypass).
REQ-030 in_feat changes after the accept edge SHALL NOT affect the result.
REQ-031 votes SHALL be 5 bits and SHALL never wrap for N_TREES <= 16.

Reset
REQ-032 rst SHALL force IDLE, out_valid=0, out_class=0, out_votes=0, out_err=0, root table=0, and internal counters=0, immediately and independent of clk.
REQ-033 Node-table contents are not reset; the bench SHALL load every node it uses.
REQ-034 rst asserted during WALK or DONE SHALL abort the sample with no out_valid pulse; after release, in_ready=1 on the first cycle.

Verification
REQ-035 Single-tree leaf-at-root: N_TREES=1, root[0]=5, node5={1,1,...} -> out_valid one cycle after accept, votes=1, class=1, err=0.
REQ-036 Depth-2 path: node0 tests feat 6 (t->1, f->2), node1 leaf 0, node2 leaf 1, in_feat[6]=0 -> votes=1, class=1, out_valid 2 cycles after accept.
REQ-037 Majority tie: N_TREES=4 with leaves 1,1,0,0 -> votes=2, class=0; with leaves 1,1,1,0 -> votes=3, class=1.
REQ-038 Depth guard: node3 non-leaf with both children pointing to 3, MAX_DEPTH=16 -> that tree ends after 16 cycles, err=1, leaf value counted as 0.
REQ-039 Backpressure and config lockout: out_ready held 0 for 10 cycles -> outputs stable and in_ready=0; a cfg_we issued in DONE leaves the table unchanged.
REQ-040 Reset mid-walk: rst pulsed in the 3rd WALK cycle -> out_valid stays 0, state returns to IDLE, and the next sample evaluates correctly.
